// File: rtl/reg_file.sv
// ============================================================================
//  Module      : reg_file
//  Description : Architectural register file with per-register rename tags
//                fed by the ROB commit port. Optional same-cycle commit
//                bypass is enabled by defining REG_FILE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
   parameter int REG_NUM      = 32,
   parameter int REG_POS_BITS = 5,
   parameter int ROB_POS_BITS = 4,
   parameter int DATA_W       = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    rollback,
   input  logic                    issue,
   input  logic [REG_POS_BITS-1:0] issue_rd,
   input  logic [ROB_POS_BITS-1:0] issue_rob_pos,
   input  logic                    reg_write,
   input  logic [REG_POS_BITS-1:0] reg_rd,
   input  logic [DATA_W-1:0]       reg_val,
   input  logic [ROB_POS_BITS-1:0] commit_rob_pos,
   input  logic [REG_POS_BITS-1:0] rs1_idx,
   output logic                    rs1_busy,
   output logic [DATA_W-1:0]       rs1_val,
   output logic [ROB_POS_BITS-1:0] rs1_rob_pos,
   input  logic [REG_POS_BITS-1:0] rs2_idx,
   output logic                    rs2_busy,
   output logic [DATA_W-1:0]       rs2_val,
   output logic [ROB_POS_BITS-1:0] rs2_rob_pos
);

   localparam int Q_W = 1 + ROB_POS_BITS + DATA_W;

   logic [DATA_W-1:0]       val [REG_NUM];
   logic [ROB_POS_BITS-1:0] tag [REG_NUM];
   logic [REG_NUM-1:0]      busy;

   logic commit_en;
   logic issue_en;

   assign commit_en = reg_write && (reg_rd != '0);
   assign issue_en  = issue && !rollback && (issue_rd != '0);

   // Issue is applied after commit so it wins busy/tag on a same-register collision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
         for (int i = 0; i < REG_NUM; i++) begin
            val[i] <= '0;
            tag[i] <= '0;
         end
      end else if (rdy) begin
         if (commit_en) begin
            val[reg_rd] <= reg_val;
            if (tag[reg_rd] == commit_rob_pos)
               busy[reg_rd] <= 1'b0;
         end
         if (rollback) begin
            busy <= '0;
         end else if (issue_en) begin
            busy[issue_rd] <= 1'b1;
            tag[issue_rd]  <= issue_rob_pos;
         end
      end
   end

   function automatic logic [Q_W-1:0] lookup(input logic [REG_POS_BITS-1:0] idx);
      logic                    b;
      logic [ROB_POS_BITS-1:0] p;
      logic [DATA_W-1:0]       v;
      b = busy[idx];
      p = tag[idx];
      v = val[idx];
`ifdef REG_FILE_BYPASS_EN
      // The decoder reads before its own issue, so an issue to idx masks the bypass.
      if (rdy && reg_write && (reg_rd == idx) && b && (p == commit_rob_pos) &&
          !(issue_en && (issue_rd == idx))) begin
         b = 1'b0;
         v = reg_val;
      end
`endif
      if (idx == '0) begin
         b = 1'b0;
         v = '0;
      end
      if (!b)
         p = '0;
      return {b, p, v};
   endfunction

   always_comb begin
      {rs1_busy, rs1_rob_pos, rs1_val} = lookup(rs1_idx);
      {rs2_busy, rs2_rob_pos, rs2_val} = lookup(rs2_idx);
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
//  Module      : tb_reg_file
//  Description : Directed and random stimulus for reg_file against a
//                register-level behavioural model. Honours REG_FILE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        rollback = 1'b0;
   logic        issue = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [3:0]  issue_rob_pos = '0;
   logic        reg_write = 1'b0;
   logic [4:0]  reg_rd = '0;
   logic [31:0] reg_val = '0;
   logic [3:0]  commit_rob_pos = '0;
   logic [4:0]  rs1_idx = '0;
   logic        rs1_busy;
   logic [31:0] rs1_val;
   logic [3:0]  rs1_rob_pos;
   logic [4:0]  rs2_idx = '0;
   logic        rs2_busy;
   logic [31:0] rs2_val;
   logic [3:0]  rs2_rob_pos;

   int vectors = 0;
   int miscompares = 0;
   logic check_en = 1'b0;

   logic [31:0] m_val  [32];
   logic        m_busy [32];
   logic [3:0]  m_tag  [32];

   reg_file dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
      .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
      .commit_rob_pos(commit_rob_pos),
      .rs1_idx(rs1_idx), .rs1_busy(rs1_busy), .rs1_val(rs1_val), .rs1_rob_pos(rs1_rob_pos),
      .rs2_idx(rs2_idx), .rs2_busy(rs2_busy), .rs2_val(rs2_val), .rs2_rob_pos(rs2_rob_pos)
   );

   always #5 clk = ~clk;

   // Model: per register, rollback clears, else an issue renames, else a matching commit retires.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < 32; r++) begin
            m_val[r]  <= '0;
            m_busy[r] <= 1'b0;
            m_tag[r]  <= '0;
         end
      end else if (rdy) begin
         for (int r = 1; r < 32; r++) begin
            if (reg_write && reg_rd == r[4:0])
               m_val[r] <= reg_val;
            if (rollback)
               m_busy[r] <= 1'b0;
            else if (issue && issue_rd == r[4:0]) begin
               m_busy[r] <= 1'b1;
               m_tag[r]  <= issue_rob_pos;
            end else if (reg_write && reg_rd == r[4:0] && m_tag[r] == commit_rob_pos)
               m_busy[r] <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_query(input logic [4:0] idx, output logic eb,
                              output logic [3:0] ep, output logic [31:0] ev);
      eb = m_busy[idx];
      ep = m_tag[idx];
      ev = m_val[idx];
`ifdef REG_FILE_BYPASS_EN
      if (rdy && reg_write && reg_rd == idx && eb && ep == commit_rob_pos &&
          !(issue && !rollback && issue_rd == idx)) begin
         eb = 1'b0;
         ev = reg_val;
      end
`endif
      if (idx == 5'd0) begin
         eb = 1'b0;
         ev = '0;
      end
   endtask

   always @(negedge clk) begin
      logic eb;
      logic [3:0] ep;
      logic [31:0] ev;
      if (check_en) begin
         model_query(rs1_idx, eb, ep, ev);
         chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, eb});
         chk("rs1_val", rs1_val, ev);
         if (eb) chk("rs1_rob_pos", {28'd0, rs1_rob_pos}, {28'd0, ep});
         model_query(rs2_idx, eb, ep, ev);
         chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, eb});
         chk("rs2_val", rs2_val, ev);
         if (eb) chk("rs2_rob_pos", {28'd0, rs2_rob_pos}, {28'd0, ep});
      end
   end

   // Hold the request across one rising edge, then drop the strobes.
   task automatic drive(input logic iss, input logic [4:0] ird, input logic [3:0] ipos,
                        input logic wr, input logic [4:0] wrd, input logic [31:0] wval,
                        input logic [3:0] wpos, input logic rb);
      issue = iss; issue_rd = ird; issue_rob_pos = ipos;
      reg_write = wr; reg_rd = wrd; reg_val = wval; commit_rob_pos = wpos;
      rollback = rb;
      @(posedge clk);
      #1;
      issue = 1'b0; reg_write = 1'b0; rollback = 1'b0;
   endtask

   task automatic q(input logic [4:0] a, input logic [4:0] b);
      rs1_idx = a;
      rs2_idx = b;
      #1;
   endtask

   initial begin
      check_en = 1'b1;
      #1;
      q(5'd5, 5'd0);
      chk("reset_busy", {31'd0, rs1_busy}, 32'd0);
      chk("reset_val", rs1_val, 32'd0);
      chk("reset_rob_pos", {28'd0, rs1_rob_pos}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Rename then retire.
      drive(1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
      q(5'd5, 5'd0);
      chk("t2_busy", {31'd0, rs1_busy}, 32'd1);
      chk("t2_rob_pos", {28'd0, rs1_rob_pos}, 32'd3);
      chk("t2_x0_busy", {31'd0, rs2_busy}, 32'd0);
      drive(1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 32'hDEAD, 4'd3, 1'b0);
      q(5'd5, 5'd0);
      chk("t2_ret_busy", {31'd0, rs1_busy}, 32'd0);
      chk("t2_ret_val", rs1_val, 32'hDEAD);

      // Stale commit leaves the younger rename in place.
      drive(1'b1, 5'd7, 4'd1, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
      drive(1'b1, 5'd7, 4'd2, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
      drive(1'b0, 5'd0, 4'd0, 1'b1, 5'd7, 32'h11, 4'd1, 1'b0);
      q(5'd7, 5'd0);
      chk("t3_val", rs1_val, 32'h11);
      chk("t3_busy", {31'd0, rs1_busy}, 32'd1);
      chk("t3_rob_pos", {28'd0, rs1_rob_pos}, 32'd2);

      // Same-register issue and commit.
      drive(1'b1, 5'd9, 4'd4, 1'b1, 5'd9, 32'h22, 4'd0, 1'b0);
      q(5'd9, 5'd0);
      chk("t4_busy", {31'd0, rs1_busy}, 32'd1);
      chk("t4_rob_pos", {28'd0, rs1_rob_pos}, 32'd4);
      chk("t4_val", rs1_val, 32'h22);

      // Rollback with simultaneous commit and issue.
      drive(1'b1, 5'd3, 4'd5, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
      drive(1'b1, 5'd4, 4'd6, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
      q(5'd3, 5'd4);
      chk("t5_pre_busy3", {31'd0, rs1_busy}, 32'd1);
      chk("t5_pre_busy4", {31'd0, rs2_busy}, 32'd1);
      drive(1'b1, 5'd6, 4'd7, 1'b1, 5'd3, 32'h33, 4'd9, 1'b1);
      q(5'd3, 5'd4);
      chk("t5_busy3", {31'd0, rs1_busy}, 32'd0);
      chk("t5_val3", rs1_val, 32'h33);
      chk("t5_busy4", {31'd0, rs2_busy}, 32'd0);
      q(5'd6, 5'd7);
      chk("t5_busy6", {31'd0, rs1_busy}, 32'd0);

      // rdy low freezes issue, commit and rollback.
      drive(1'b1, 5'd11, 4'd3, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
      rdy = 1'b0;
      drive(1'b1, 5'd10, 4'd2, 1'b1, 5'd5, 32'h55, 4'd0, 1'b0);
      q(5'd10, 5'd5);
      chk("rdy_busy10", {31'd0, rs1_busy}, 32'd0);
      chk("rdy_val5", rs2_val, 32'hDEAD);
      drive(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b1);
      q(5'd11, 5'd0);
      chk("rdy_rb_busy11", {31'd0, rs1_busy}, 32'd1);
      chk("rdy_rb_pos11", {28'd0, rs1_rob_pos}, 32'd3);
      rdy = 1'b1;

      // x0 ignores writes and issues.
      drive(1'b1, 5'd0, 4'd1, 1'b1, 5'd0, 32'hFF, 4'd0, 1'b0);
      q(5'd0, 5'd0);
      chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
      chk("x0_val", rs1_val, 32'd0);

      // Same-cycle commit visibility, with and without a competing issue.
      drive(1'b1, 5'd12, 4'd8, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
      reg_write = 1'b1; reg_rd = 5'd12; commit_rob_pos = 4'd8; reg_val = 32'hABC;
      q(5'd12, 5'd0);
`ifdef REG_FILE_BYPASS_EN
      chk("byp_busy", {31'd0, rs1_busy}, 32'd0);
      chk("byp_val", rs1_val, 32'hABC);
`else
      chk("nobyp_busy", {31'd0, rs1_busy}, 32'd1);
      chk("nobyp_pos", {28'd0, rs1_rob_pos}, 32'd8);
`endif
      issue = 1'b1; issue_rd = 5'd12; issue_rob_pos = 4'd9;
      q(5'd12, 5'd0);
      chk("byp_iss_busy", {31'd0, rs1_busy}, 32'd1);
      chk("byp_iss_pos", {28'd0, rs1_rob_pos}, 32'd8);
      @(posedge clk);
      #1;
      issue = 1'b0; reg_write = 1'b0;
      q(5'd12, 5'd0);
      chk("coll_busy", {31'd0, rs1_busy}, 32'd1);
      chk("coll_pos", {28'd0, rs1_rob_pos}, 32'd9);
      chk("coll_val", rs1_val, 32'hABC);

      // Asynchronous reset mid-run.
      @(posedge clk);
      #1 rst = 1'b0;
      q(5'd7, 5'd12);
      chk("mid_rst_busy7", {31'd0, rs1_busy}, 32'd0);
      chk("mid_rst_val7", rs1_val, 32'd0);
      chk("mid_rst_busy12", {31'd0, rs2_busy}, 32'd0);
      chk("mid_rst_val12", rs2_val, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Random traffic, checked every cycle against the model.
      for (int n = 0; n < 400; n++) begin
         @(posedge clk);
         #1;
         rdy       = ($urandom_range(7) != 0);
         rollback  = ($urandom_range(15) == 0);
         issue     = $urandom_range(1);
         issue_rd  = 5'($urandom_range(31));
         issue_rob_pos = 4'($urandom_range(15));
         reg_write = $urandom_range(1);
         reg_rd    = 5'($urandom_range(31));
         reg_val   = $urandom;
         commit_rob_pos = $urandom_range(1) ? m_tag[reg_rd] : 4'($urandom_range(15));
         rs1_idx   = $urandom_range(1) ? reg_rd : 5'($urandom_range(31));
         rs2_idx   = $urandom_range(1) ? issue_rd : 5'($urandom_range(31));
      end
      @(posedge clk);
      #1;
      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
